// File: rtl/i2c_master.sv
// i2c_master: single-byte I2C master (write or read one byte) on open-drain SCL/SDA.
// Define I2C_MASTER_CLK_STRETCH_EN to let a slave stretch SCL.
module i2c_master #(
  parameter int CLK_DIV = 250
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [6:0] addr,
  input  logic       rw,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  output logic       busy,
  output logic       done,
  output logic       ack_err,
  inout  wire        scl,
  inout  wire        sda
);
  localparam logic [3:0] IDLE       = 4'd0;
  localparam logic [3:0] START      = 4'd1;
  localparam logic [3:0] ADDR       = 4'd2;
  localparam logic [3:0] ADDR_ACK   = 4'd3;
  localparam logic [3:0] WDATA      = 4'd4;
  localparam logic [3:0] WDATA_ACK  = 4'd5;
  localparam logic [3:0] RDATA      = 4'd6;
  localparam logic [3:0] RDATA_NACK = 4'd7;
  localparam logic [3:0] STOP       = 4'd8;
  logic [3:0]  state;
  logic [15:0] div;
  logic [1:0]  q;
  logic [2:0]  bitc;
  logic [7:0]  sreg;
  logic [7:0]  wdata_q;
  logic        rw_q;
  logic        sda_low;
  logic        scl_low;
  logic        sda_nxt;
  logic        smp;
  logic        tick;
  logic        bend;
  logic        hold;
  assign scl  = scl_low ? 1'b0 : 1'bz;
  assign sda  = sda_low ? 1'b0 : 1'bz;
  assign tick = div == 16'(CLK_DIV - 1);
  assign bend = tick && q == 2'd3;
  always_comb begin
    scl_low = (state == IDLE)  ? 1'b0 :
              (state == START) ? q[1] :
              (state == STOP)  ? (q == 2'd0) : !q[1];
    sda_nxt = (state == START) ? 1'b1 :
              (state == ADDR || state == WDATA) ? !sreg[7] :
              (state == STOP)  ? (q != 2'd3) : 1'b0;
  end
`ifdef I2C_MASTER_CLK_STRETCH_EN
  logic [1:0] scl_sync;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) scl_sync <= 2'b00;
    else scl_sync <= {scl_sync[0], scl};
  // Hold at the start of a released-SCL quarter until the bus really reads high.
  assign hold = q == 2'd2 && div == 16'd0 && !scl_low && !scl_sync[1];
`else
  assign hold = 1'b0;
`endif
  // SDA drive is registered, so every SDA change lands one clk after the SCL edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      div     <= '0;
      q       <= '0;
      bitc    <= '0;
      sreg    <= '0;
      wdata_q <= '0;
      rw_q    <= 1'b0;
      sda_low <= 1'b0;
      smp     <= 1'b0;
      rdata   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      ack_err <= 1'b0;
    end else begin
      done    <= 1'b0;
      sda_low <= sda_nxt;
      if (state == IDLE) begin
        div  <= '0;
        q    <= '0;
        bitc <= '0;
        if (start) begin
          state   <= START;
          sreg    <= {addr, rw};
          wdata_q <= wdata;
          rw_q    <= rw;
          busy    <= 1'b1;
          ack_err <= 1'b0;
        end
      end else if (!hold) begin
        div <= tick ? 16'd0 : div + 16'd1;
        if (tick) q <= q + 2'd1;
        if (tick && q == 2'd2) begin
          smp <= sda;
          if (state == RDATA) sreg <= {sreg[6:0], sda};
        end
        if (bend) begin
          case (state)
            START: state <= ADDR;
            ADDR, WDATA: begin
              sreg <= {sreg[6:0], 1'b0};
              bitc <= bitc + 3'd1;
              if (bitc == 3'd7) state <= (state == ADDR) ? ADDR_ACK : WDATA_ACK;
            end
            ADDR_ACK: begin
              ack_err <= smp;
              sreg    <= wdata_q;
              state   <= smp ? STOP : rw_q ? RDATA : WDATA;
            end
            WDATA_ACK: begin
              ack_err <= smp;
              state   <= STOP;
            end
            RDATA: begin
              bitc <= bitc + 3'd1;
              if (bitc == 3'd7) begin
                rdata <= sreg;
                state <= RDATA_NACK;
              end
            end
            RDATA_NACK: state <= STOP;
            STOP: begin
              state <= IDLE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
            default: state <= IDLE;
          endcase
        end
      end
    end
  end
endmodule

// File: tb/tb_i2c_master.sv
// tb_i2c_master: directed vectors against a behavioural I2C slave at address 7'h0E.
module tb_i2c_master;
  localparam int CD = 4;
`ifdef I2C_MASTER_CLK_STRETCH_EN
  localparam int LAT_FULL = 356;
  localparam int LAT_NACK = 194;
`else
  localparam int LAT_FULL = 320;
  localparam int LAT_NACK = 176;
`endif
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [6:0] addr = '0;
  logic       rw = 1'b0;
  logic [7:0] wdata = '0;
  logic [7:0] rdata;
  logic       busy;
  logic       done;
  logic       ack_err;
  wire        scl;
  wire        sda;
  logic       s_scl_low = 1'b0;
  logic       s_sda_low = 1'b0;
  pullup (scl);
  pullup (sda);
  assign scl = s_scl_low ? 1'b0 : 1'bz;
  assign sda = s_sda_low ? 1'b0 : 1'bz;
  i2c_master #(.CLK_DIV(CD)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .addr(addr), .rw(rw), .wdata(wdata),
    .rdata(rdata), .busy(busy), .done(done), .ack_err(ack_err), .scl(scl), .sda(sda)
  );
  always #5 clk = ~clk;
  int checks = 0;
  int failures = 0;
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", n, a, e);
    end
  endtask
  // Slave: oversamples the bus at negedge clk and decodes START/STOP/bits.
  logic       ps = 1'b1, pd = 1'b1, cs, cd;
  logic       act = 1'b0, hit = 1'b0, rd_mode = 1'b0, m_ack = 1'b0, stretch_req = 1'b0;
  logic [7:0] sh = '0, rd_byte = '0, bus0 = '0, bus1 = '0;
  int         bitn = 0, byten = 0, stops = 0, hold = 0;
  always @(negedge clk) begin
    cs = scl;
    cd = sda;
    if (hold > 0) begin
      hold--;
      if (hold == 0) s_scl_low = 1'b0;
    end
    if (ps && cs && pd && !cd) begin
      act = 1'b1; bitn = 0; byten = 0; s_sda_low = 1'b0;
    end else if (ps && cs && !pd && cd) begin
      act = 1'b0; stops++; s_sda_low = 1'b0;
    end else if (act && !ps && cs) begin
      if (bitn < 8) begin
        sh = {sh[6:0], cd};
        bitn++;
      end else begin
        if (rd_mode && byten == 1) m_ack = cd;
        bitn = 9;
      end
    end else if (act && ps && !cs) begin
      if (bitn == 8) begin
        if (byten == 0) begin
          bus0 = sh; hit = (sh[7:1] == 7'h0E); rd_mode = sh[0]; s_sda_low = hit;
        end else if (!rd_mode) begin
          bus1 = sh; s_sda_low = hit;
        end else s_sda_low = 1'b0;
      end else if (bitn == 9) begin
        byten++;
        bitn = 0;
        s_sda_low = hit && rd_mode && byten == 1 && !rd_byte[7];
        if (stretch_req && hit && byten == 1) begin
          s_scl_low = 1'b1; hold = 100; stretch_req = 1'b0;
        end
      end else if (rd_mode && hit && byten == 1 && bitn > 0) s_sda_low = !rd_byte[7-bitn];
    end
    ps = cs;
    pd = cd;
  end
  task automatic run(input logic [6:0] a, input logic r, input logic [7:0] w, output int lat);
    addr = a; rw = r; wdata = w; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_on_accept", busy, 1'b1);
    lat = 0;
    while (!done && lat < 3000) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("busy_at_done", busy, 1'b0);
    @(posedge clk); #1;
    chk("done_one_cycle", done, 1'b0);
  endtask
  typedef struct {
    logic [6:0] a; logic r; logic [7:0] w; logic [7:0] srd;
    int lat; logic err; logic [7:0] b0; logic [7:0] b1; logic [7:0] rd;
  } vec_t;
  vec_t v[7];
  int lat, st0, n, ndone;
  initial begin
    v[0] = '{7'h0E, 1'b0, 8'hA5, 8'h00, LAT_FULL, 1'b0, 8'h1C, 8'hA5, 8'h00};
    v[1] = '{7'h0E, 1'b1, 8'h00, 8'h3C, LAT_FULL, 1'b0, 8'h1D, 8'h00, 8'h3C};
    v[2] = '{7'h15, 1'b0, 8'h77, 8'h00, LAT_NACK, 1'b1, 8'h2A, 8'h00, 8'h00};
    v[3] = '{7'h0E, 1'b0, 8'h81, 8'h00, LAT_FULL, 1'b0, 8'h1C, 8'h81, 8'h00};
    v[4] = '{7'h0E, 1'b1, 8'h00, 8'hFF, LAT_FULL, 1'b0, 8'h1D, 8'h00, 8'hFF};
    v[5] = '{7'h0E, 1'b1, 8'h00, 8'h00, LAT_FULL, 1'b0, 8'h1D, 8'h00, 8'h00};
    v[6] = '{7'h15, 1'b1, 8'h00, 8'h00, LAT_NACK, 1'b1, 8'h2B, 8'h00, 8'h00};
    repeat (3) @(posedge clk);
    #1;
    chk("rst_scl", scl, 1'b1);
    chk("rst_sda", sda, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_ack_err", ack_err, 1'b0);
    chk("rst_rdata", rdata, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 7; i++) begin
      bus0 = '0; bus1 = '0; m_ack = 1'b0; rd_byte = v[i].srd; st0 = stops;
      run(v[i].a, v[i].r, v[i].w, lat);
      chk($sformatf("v%0d_latency", i), lat, v[i].lat);
      chk($sformatf("v%0d_ack_err", i), ack_err, v[i].err);
      chk($sformatf("v%0d_addr_byte", i), bus0, v[i].b0);
      chk($sformatf("v%0d_stop", i), stops, st0 + 1);
      if (!v[i].r) chk($sformatf("v%0d_data_byte", i), bus1, v[i].b1);
      if (v[i].r && !v[i].err) begin
        chk($sformatf("v%0d_rdata", i), rdata, v[i].rd);
        chk($sformatf("v%0d_master_nack", i), m_ack, 1'b1);
      end
      repeat (5) @(negedge clk);
    end
    // start pulses while busy, with inputs changing under the transaction
    bus0 = '0; bus1 = '0; ndone = 0;
    addr = 7'h0E; rw = 1'b0; wdata = 8'hA5; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; addr = 7'h15; rw = 1'b1; wdata = 8'hFF;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      start = (i % 97 == 10) && i < 300;
      if (done) ndone++;
    end
    start = 1'b0;
    chk("busy_start_dones", ndone, 1);
    chk("busy_start_addr", bus0, 8'h1C);
    chk("busy_start_data", bus1, 8'hA5);
    chk("busy_start_ack_err", ack_err, 1'b0);
    // reset in the middle of the data byte
    addr = 7'h0E; rw = 1'b0; wdata = 8'hC3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    while (!(byten == 1 && bitn == 4) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("rst_mid_reached", n < 1000, 1'b1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_scl", scl, 1'b1);
    chk("rst_mid_sda", sda, 1'b1);
    chk("rst_mid_busy", busy, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    bus0 = '0; bus1 = '0;
    run(7'h0E, 1'b0, 8'h3C, lat);
    chk("after_rst_latency", lat, LAT_FULL);
    chk("after_rst_data", bus1, 8'h3C);
    chk("after_rst_ack_err", ack_err, 1'b0);
    repeat (5) @(negedge clk);
    // slave stretches SCL for 100 cycles after the address ACK
    bus0 = '0; bus1 = '0; stretch_req = 1'b1;
    run(7'h0E, 1'b0, 8'hA5, lat);
`ifdef I2C_MASTER_CLK_STRETCH_EN
    chk("stretch_delayed", lat >= 420 && lat < 3000, 1'b1);
    chk("stretch_data", bus1, 8'hA5);
    chk("stretch_ack_err", ack_err, 1'b0);
`else
    chk("stretch_ignored_latency", lat, 320);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end
endmodule
